// File: rtl/sram_like_slave_responder.sv
// sram_like_slave_responder: responder end of the sram_like bus.
// Accepts address-phase handshakes into a small in-order FIFO and serves
// each entry on a single-port synchronous SRAM. An optional wait phase can
// be inserted before every access. Each accepted request gets exactly one
// data_ok pulse, and responses come back in acceptance order.
module sram_like_slave_responder #(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 0,
  parameter int RAM_AW  = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Advance a FIFO pointer, wrapping modulo DEPTH.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return PW'(0);
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Byte-lane write enables for a given transfer size and low address bits.
  function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      2'd0:    be = 4'b0001 << lo;
      2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  logic        q_wr    [DEPTH];
  logic [1:0]  q_size  [DEPTH];
  logic [31:0] q_addr  [DEPTH];
  logic [31:0] q_wdata [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  state_t        state;
  state_t        state_next;
  logic [3:0]    cnt;
  logic [3:0]    cnt_next;
  logic          push;
  logic          pop;
  logic          head_wr;
  logic [1:0]    head_size;
  logic [31:0]   head_addr;
  logic [31:0]   head_wdata;

  // Accept only while there is room; a pop in this cycle does not free a slot yet.
  assign addr_ok    = req && !reset && (count < CW'(DEPTH));
  assign push       = req && addr_ok;
  assign pop        = (state == S_RESP);
  assign head_wr    = q_wr[head];
  assign head_size  = q_size[head];
  assign head_addr  = q_addr[head];
  assign head_wdata = q_wdata[head];

  // FIFO payload storage, written at the tail on each handshake.
  always_ff @(posedge clock) begin
    if (push) begin
      q_wr[tail]    <= wr;
      q_size[tail]  <= size;
      q_addr[tail]  <= addr;
      q_wdata[tail] <= wdata;
    end
  end

  // FIFO pointers and occupancy; reset discards every pending entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= PW'(0);
      tail  <= PW'(0);
      count <= CW'(0);
    end else begin
      if (push) begin
        tail <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Service FSM state and wait counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: optional wait phase, one access, one response per entry.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE, S_RESP: begin
        // From RESP only a second entry keeps the pipeline going; the
        // entry being popped is still counted this cycle.
        if ((state == S_IDLE && count != CW'(0)) || (state == S_RESP && count > CW'(1))) begin
          if (LATENCY > 0) begin
            state_next = S_WAIT;
            cnt_next   = WAIT_INIT;
          end else begin
            state_next = S_ACCESS;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = S_ACCESS;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_ACCESS: state_next = S_RESP;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output decode: SRAM port driven only in ACCESS, response only in RESP.
  always_comb begin
    ram_en    = 1'b0;
    ram_wen   = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'd0;
    data_ok   = 1'b0;
    rdata     = 32'd0;
    if (!reset && state == S_ACCESS) begin
      ram_en    = 1'b1;
      ram_addr  = head_addr[RAM_AW+1:2];
      ram_wdata = head_wdata;
      if (head_wr) begin
        ram_wen = byte_enables(head_size, head_addr[1:0]);
      end else begin
        ram_wen = 4'b0000;
      end
    end else if (!reset && state == S_RESP) begin
      data_ok = 1'b1;
      if (head_wr) begin
        rdata = 32'd0;
      end else begin
        rdata = ram_rdata;
      end
    end else begin
      data_ok = 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_like_slave_responder.sv
// Self-checking bench for sram_like_slave_responder: one instance with no
// extra latency and one with LATENCY=3, sharing stimulus, each with its own
// SRAM model.
module tb_sram_like_slave_responder;

  logic        clock;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        addr_ok0, data_ok0, ram_en0;
  logic [31:0] rdata0, ram_wdata0, ram_rdata0;
  logic [3:0]  ram_wen0;
  logic [13:0] ram_addr0;
  logic        addr_ok3, data_ok3, ram_en3;
  logic [31:0] rdata3, ram_wdata3, ram_rdata3;
  logic [3:0]  ram_wen3;
  logic [13:0] ram_addr3;

  logic [31:0] mem0 [0:16383];
  logic [31:0] mem3 [0:16383];

  int checks = 0;
  int errors = 0;

  sram_like_slave_responder #(.DEPTH(2), .LATENCY(0), .RAM_AW(14)) dut0 (
    .clock(clock), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0),
    .ram_en(ram_en0), .ram_wen(ram_wen0), .ram_addr(ram_addr0),
    .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
  );

  sram_like_slave_responder #(.DEPTH(2), .LATENCY(3), .RAM_AW(14)) dut3 (
    .clock(clock), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok3), .data_ok(data_ok3), .rdata(rdata3),
    .ram_en(ram_en3), .ram_wen(ram_wen3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model for the zero-latency instance.
  always @(posedge clock) begin
    if (ram_en0) begin
      if (ram_wen0 == 4'b0000) begin
        ram_rdata0 <= mem0[ram_addr0];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ram_wen0[b]) mem0[ram_addr0][b*8 +: 8] <= ram_wdata0[b*8 +: 8];
        end
      end
    end
  end

  // SRAM model for the LATENCY=3 instance.
  always @(posedge clock) begin
    if (ram_en3) begin
      if (ram_wen3 == 4'b0000) begin
        ram_rdata3 <= mem3[ram_addr3];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ram_wen3[b]) mem3[ram_addr3][b*8 +: 8] <= ram_wdata3[b*8 +: 8];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_wen;
    logic [13:0] exp_ram_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
    ram_rdata0 = 32'd0; ram_rdata3 = 32'd0;
    for (int i = 0; i < 16384; i++) begin
      mem0[i] = 32'd0;
      mem3[i] = 32'd0;
    end
    mem0[4] = 32'hDEADBEEF; mem3[4] = 32'hDEADBEEF;
    mem0[5] = 32'h11111111; mem3[5] = 32'h11111111;
    mem0[6] = 32'h22222222; mem3[6] = 32'h22222222;

    vecs[0]  = '{1'b0, 2'd0+2'd2, 32'h10, 32'h0,        4'b0000, 14'd4,  32'hDEADBEEF};
    vecs[1]  = '{1'b1, 2'd0,      32'h23, 32'h55555555, 4'b1000, 14'd8,  32'h0};
    vecs[2]  = '{1'b1, 2'd1,      32'h22, 32'h55555555, 4'b1100, 14'd8,  32'h0};
    vecs[3]  = '{1'b0, 2'd2,      32'h20, 32'h0,        4'b0000, 14'd8,  32'h55550000};
    vecs[4]  = '{1'b1, 2'd0,      32'h20, 32'hAAAAAAAA, 4'b0001, 14'd8,  32'h0};
    vecs[5]  = '{1'b0, 2'd1,      32'h21, 32'h0,        4'b0000, 14'd8,  32'h555500AA};
    vecs[6]  = '{1'b1, 2'd3,      32'h24, 32'h12345678, 4'b1111, 14'd9,  32'h0};
    vecs[7]  = '{1'b0, 2'd2,      32'h27, 32'h0,        4'b0000, 14'd9,  32'h12345678};
    vecs[8]  = '{1'b1, 2'd1,      32'h21, 32'h99999999, 4'b0011, 14'd8,  32'h0};
    vecs[9]  = '{1'b0, 2'd2,      32'h20, 32'h0,        4'b0000, 14'd8,  32'h55559999};
    vecs[10] = '{1'b1, 2'd2,      32'h2A, 32'hCAFEF00D, 4'b1111, 14'd10, 32'h0};

    // Reset state, with req held high during reset.
    @(negedge clock);
    req = 1'b1; addr = 32'h10;
    #1;
    chk("rst_addr_ok", {31'd0, addr_ok0}, 32'd0);
    chk("rst_data_ok", {31'd0, data_ok0}, 32'd0);
    chk("rst_rdata", rdata0, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en0}, 32'd0);
    chk("rst_ram_wen", {28'd0, ram_wen0}, 32'd0);
    chk("rst_ram_addr", {18'd0, ram_addr0}, 32'd0);
    chk("rst_ram_wdata", ram_wdata0, 32'd0);
    do_reset();

    // Table: single transactions on the zero-latency instance.
    for (int v = 0; v < 11; v++) begin
      @(negedge clock);
      req = 1'b1; wr = vecs[v].wr; size = vecs[v].size;
      addr = vecs[v].addr; wdata = vecs[v].wdata;
      #1;
      chk($sformatf("v%0d_addr_ok", v), {31'd0, addr_ok0}, 32'd1);
      @(negedge clock);
      req = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
      #1;
      chk($sformatf("v%0d_c1_ram_en", v), {31'd0, ram_en0}, 32'd0);
      @(negedge clock); #1;
      chk($sformatf("v%0d_c2_ram_en", v), {31'd0, ram_en0}, 32'd1);
      chk($sformatf("v%0d_c2_ram_wen", v), {28'd0, ram_wen0}, {28'd0, vecs[v].exp_wen});
      chk($sformatf("v%0d_c2_ram_addr", v), {18'd0, ram_addr0}, {18'd0, vecs[v].exp_ram_addr});
      chk($sformatf("v%0d_c2_ram_wdata", v), ram_wdata0, vecs[v].wdata);
      @(negedge clock); #1;
      chk($sformatf("v%0d_c3_data_ok", v), {31'd0, data_ok0}, 32'd1);
      chk($sformatf("v%0d_c3_rdata", v), rdata0, vecs[v].exp_rdata);
      chk($sformatf("v%0d_c3_ram_en", v), {31'd0, ram_en0}, 32'd0);
      @(negedge clock); #1;
      chk($sformatf("v%0d_c4_data_ok", v), {31'd0, data_ok0}, 32'd0);
      chk($sformatf("v%0d_c4_rdata", v), rdata0, 32'd0);
    end

    // Back-pressure: three reads with req held high, DEPTH=2.
    do_reset();
    @(negedge clock);
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10; #1;
    chk("bp_c0_addr_ok", {31'd0, addr_ok0}, 32'd1);
    @(negedge clock); addr = 32'h14; #1;
    chk("bp_c1_addr_ok", {31'd0, addr_ok0}, 32'd1);
    @(negedge clock); addr = 32'h18; #1;
    chk("bp_c2_addr_ok", {31'd0, addr_ok0}, 32'd0);
    chk("bp_c2_ram_addr", {18'd0, ram_addr0}, 32'd4);
    @(negedge clock); #1;
    chk("bp_c3_addr_ok_full", {31'd0, addr_ok0}, 32'd0);
    chk("bp_c3_data_ok", {31'd0, data_ok0}, 32'd1);
    chk("bp_c3_rdata_A", rdata0, 32'hDEADBEEF);
    @(negedge clock); #1;
    chk("bp_c4_addr_ok", {31'd0, addr_ok0}, 32'd1);
    chk("bp_c4_data_ok", {31'd0, data_ok0}, 32'd0);
    @(negedge clock); req = 1'b0; #1;
    chk("bp_c5_data_ok", {31'd0, data_ok0}, 32'd1);
    chk("bp_c5_rdata_B", rdata0, 32'h11111111);
    @(negedge clock); #1;
    chk("bp_c6_data_ok", {31'd0, data_ok0}, 32'd0);
    @(negedge clock); #1;
    chk("bp_c7_data_ok", {31'd0, data_ok0}, 32'd1);
    chk("bp_c7_rdata_C", rdata0, 32'h22222222);
    @(negedge clock); #1;
    chk("bp_c8_data_ok", {31'd0, data_ok0}, 32'd0);

    // LATENCY=3: single read responds in cycle 6.
    do_reset();
    @(negedge clock);
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10; #1;
    chk("l3_c0_addr_ok", {31'd0, addr_ok3}, 32'd1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock); req = 1'b0; addr = 32'd0; #1;
      chk($sformatf("l3_c%0d_ram_en", c), {31'd0, ram_en3}, {31'd0, c == 5});
      chk($sformatf("l3_c%0d_data_ok", c), {31'd0, data_ok3}, {31'd0, c == 6});
      if (c == 6) chk("l3_rdata", rdata3, 32'hDEADBEEF);
    end

    // LATENCY=3: back-to-back reads complete 5 cycles apart.
    do_reset();
    @(negedge clock);
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h14; #1;
    chk("l3bb_c0_addr_ok", {31'd0, addr_ok3}, 32'd1);
    @(negedge clock); addr = 32'h18; #1;
    chk("l3bb_c1_addr_ok", {31'd0, addr_ok3}, 32'd1);
    for (int c = 2; c <= 12; c++) begin
      @(negedge clock); req = 1'b0; addr = 32'd0; #1;
      chk($sformatf("l3bb_c%0d_data_ok", c), {31'd0, data_ok3}, {31'd0, c == 6 || c == 11});
      if (c == 6)  chk("l3bb_rdata_A", rdata3, 32'h11111111);
      if (c == 11) chk("l3bb_rdata_B", rdata3, 32'h22222222);
    end

    // Reset while two entries wait: they are discarded, later traffic is normal.
    do_reset();
    @(negedge clock); req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10;
    @(negedge clock); addr = 32'h14;
    @(negedge clock); req = 1'b0; addr = 32'd0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("rw_quiet%0d_data_ok3", c), {31'd0, data_ok3}, 32'd0);
      chk($sformatf("rw_quiet%0d_data_ok0", c), {31'd0, data_ok0}, 32'd0);
      @(negedge clock);
    end
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h18; #1;
    chk("rw_c0_addr_ok", {31'd0, addr_ok0}, 32'd1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock); req = 1'b0; addr = 32'd0; #1;
      chk($sformatf("rw_c%0d_data_ok0", c), {31'd0, data_ok0}, {31'd0, c == 3});
      chk($sformatf("rw_c%0d_data_ok3", c), {31'd0, data_ok3}, {31'd0, c == 6});
      if (c == 3) chk("rw_rdata0", rdata0, 32'h22222222);
      if (c == 6) chk("rw_rdata3", rdata3, 32'h22222222);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
